// File: rtl/hdmi_timing_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_timing_ctrl_pkg
// Shared definitions for the HDMI video timing controller:
//   - default 640x480@60 timing parameter set
//   - FSM state type (ST_IDLE, ST_RUN)
//   - counter width used for the h/v position counters
// -----------------------------------------------------------------------------
package hdmi_timing_ctrl_pkg;

    localparam int unsigned CNT_W = 12;

    // 640x480@60 timing set
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/hdmi_timing_ctrl_wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Free-running counter 0..TERMINAL that wraps to 0, with synchronous clear.
// Ports:
//   clk    in  : clock
//   rst_n  in  : asynchronous active-low reset
//   clr    in  : synchronous clear to 0 (dominates en)
//   en     in  : advance the count this cycle
//   cnt    out : current count
//   carry  out : high in the enabled cycle where cnt == TERMINAL (wrap cycle)
// -----------------------------------------------------------------------------
module wrap_counter
    import hdmi_timing_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = CNT_W,
    parameter int unsigned TERMINAL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             carry
);

    localparam logic [WIDTH-1:0] TC = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        carry = en && (cnt_q == TC);
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = carry ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// -----------------------------------------------------------------------------
// hdmi_timing_ctrl
// Video timing controller for the HDMI output path. Produces the pixel FIFO
// read strobe, then one cycle later the data enable, syncs and pixel position,
// so FIFO read data lines up with the sync outputs at the formatter.
// Ports:
//   clk          in  : pixel clock
//   reset        in  : asynchronous active-low reset
//   enable       in  : request video output (frame always completes on drop)
//   fifo_empty   in  : pixel FIFO empty flag
//   clr_underrun in  : clear sticky underrun flag
//   rd_en        out : pixel FIFO read strobe (stage 0)
//   en           out : data enable (stage 1)
//   hs, vs       out : horizontal / vertical sync (stage 1, polarity by param)
//   pix_x, pix_y out : position of the pixel qualified by en
//   frame_start  out : one-cycle pulse with rd_en of position (0,0)
//   busy         out : high while in RUN
//   underrun     out : sticky, set on rd_en with fifo_empty
// -----------------------------------------------------------------------------
module hdmi_timing_ctrl
    import hdmi_timing_ctrl_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic             clr_underrun,
    output logic             rd_en,
    output logic             en,
    output logic             hs,
    output logic             vs,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start,
    output logic             busy,
    output logic             underrun
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // ---------------------------------------------------------------- FSM
    state_t state_q, state_d;
    logic   busy_q, busy_d;
    logic   run;

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_carry, v_carry;

    assign run = (state_q == ST_RUN);

    // v_carry is only high on the last position of a frame (it is gated by
    // h_carry), so it doubles as the frame-end marker.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (enable)              state_d = ST_RUN;
            ST_RUN:  if (v_carry && !enable)  state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
    end

    // ------------------------------------------------------------ counters
    wrap_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (H_TOTAL - 1)
    ) u_h_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (!run),
        .en    (run),
        .cnt   (h_cnt),
        .carry (h_carry)
    );

    wrap_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (V_TOTAL - 1)
    ) u_v_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (!run),
        .en    (h_carry),
        .cnt   (v_cnt),
        .carry (v_carry)
    );

    // ------------------------------------------------------------- stage 0
    logic             rd_en_q, rd_en_d;
    logic             hs0_q, hs0_d;
    logic             vs0_q, vs0_d;
    logic             fs_q, fs_d;
    logic [CNT_W-1:0] x0_q, x0_d;
    logic [CNT_W-1:0] y0_q, y0_d;

    always_comb begin
        rd_en_d = run && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        hs0_d   = (run && (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C)) ? HS_POL : ~HS_POL;
        vs0_d   = (run && (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C)) ? VS_POL : ~VS_POL;
        fs_d    = run && (h_cnt == '0) && (v_cnt == '0);
        x0_d    = h_cnt;
        y0_d    = v_cnt;
    end

    // ------------------------------------------------------------- stage 1
    logic             en_q, en_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic [CNT_W-1:0] pix_x_q, pix_x_d;
    logic [CNT_W-1:0] pix_y_q, pix_y_d;
    logic             underrun_q, underrun_d;

    always_comb begin
        en_d    = rd_en_q;
        hs_d    = hs0_q;
        vs_d    = vs0_q;
        pix_x_d = x0_q;
        pix_y_d = y0_q;

        // set has priority over clear
        underrun_d = underrun_q;
        if (clr_underrun)          underrun_d = 1'b0;
        if (rd_en_q && fifo_empty) underrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            hs0_q      <= ~HS_POL;
            vs0_q      <= ~VS_POL;
            fs_q       <= 1'b0;
            x0_q       <= '0;
            y0_q       <= '0;
            en_q       <= 1'b0;
            hs_q       <= ~HS_POL;
            vs_q       <= ~VS_POL;
            pix_x_q    <= '0;
            pix_y_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            rd_en_q    <= rd_en_d;
            hs0_q      <= hs0_d;
            vs0_q      <= vs0_d;
            fs_q       <= fs_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            en_q       <= en_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            pix_x_q    <= pix_x_d;
            pix_y_q    <= pix_y_d;
            underrun_q <= underrun_d;
        end
    end

    assign rd_en       = rd_en_q;
    assign en          = en_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hdmi_timing_ctrl
// Directed bench for hdmi_timing_ctrl using a reduced timing set:
// H 8/2/3/2 (H_TOTAL=15), V 4/1/2/1 (V_TOTAL=8), frame = 120 clocks.
// Two instances share the stimulus: one with active-low syncs, one with
// active-high syncs. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_hdmi_timing_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        fifo_empty;
    logic        clr_underrun;

    logic        rd_en, en, hs, vs, frame_start, busy, underrun;
    logic [11:0] pix_x, pix_y;

    logic        rd_en_p, en_p, hs_p, vs_p, frame_start_p, busy_p, underrun_p;
    logic [11:0] pix_x_p, pix_y_p;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hdmi_timing_ctrl #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HS_POL   (1'b0), .VS_POL (1'b0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .clr_underrun (clr_underrun),
        .rd_en        (rd_en),
        .en           (en),
        .hs           (hs),
        .vs           (vs),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .frame_start  (frame_start),
        .busy         (busy),
        .underrun     (underrun)
    );

    hdmi_timing_ctrl #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HS_POL   (1'b1), .VS_POL (1'b1)
    ) dut_p (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .clr_underrun (clr_underrun),
        .rd_en        (rd_en_p),
        .en           (en_p),
        .hs           (hs_p),
        .vs           (vs_p),
        .pix_x        (pix_x_p),
        .pix_y        (pix_y_p),
        .frame_start  (frame_start_p),
        .busy         (busy_p),
        .underrun     (underrun_p)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected stage-0 decode of a position p counted in clocks since the
    // IDLE->RUN edge; positions outside the 2-frame run window are idle.
    function automatic void decode(input int p, output logic rd, output logic hsa,
                                   output logic vsa, output logic fs,
                                   output int hh, output int vv);
        int pp;
        rd = 1'b0; hsa = 1'b0; vsa = 1'b0; fs = 1'b0; hh = 0; vv = 0;
        if (p >= 0 && p < 240) begin
            pp  = p % 120;
            hh  = pp % 15;
            vv  = pp / 15;
            rd  = (hh < 8) && (vv < 4);
            hsa = (hh >= 10) && (hh < 13);
            vsa = (vv >= 5) && (vv < 7);
            fs  = (pp == 0);
        end
    endfunction

    task automatic wait_rd(input logic val, input string tag);
        int k = 0;
        while (rd_en !== val && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'b0, rd_en}, {31'b0, val});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_en"}, {31'b0, rd_en}, 32'd0);
        chk({tag, "_en"},    {31'b0, en},    32'd0);
        chk({tag, "_hs"},    {31'b0, hs},    32'd1);
        chk({tag, "_vs"},    {31'b0, vs},    32'd1);
        chk({tag, "_hs_p"},  {31'b0, hs_p},  32'd0);
        chk({tag, "_vs_p"},  {31'b0, vs_p},  32'd0);
        chk({tag, "_pix_x"}, {20'b0, pix_x}, 32'd0);
        chk({tag, "_pix_y"}, {20'b0, pix_y}, 32'd0);
        chk({tag, "_fs"},    {31'b0, frame_start}, 32'd0);
        chk({tag, "_busy"},  {31'b0, busy},  32'd0);
        chk({tag, "_under"}, {31'b0, underrun}, 32'd0);
    endtask

    initial begin
        logic rd_e, hs0, vs0, fs_e, en_e, hs1, vs1, fs_x;
        int   x1, y1, x2, y2, k;
        int   cnt_rd, cnt_en, cnt_hs, cnt_vs, cnt_fs;

        cnt_rd = 0; cnt_en = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0;

        // reset
        reset = 1'b0; enable = 1'b0; fifo_empty = 1'b0; clr_underrun = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");

        reset = 1'b1;
        @(negedge clk);
        chk("idle_busy",  {31'b0, busy},  32'd0);
        chk("idle_rd_en", {31'b0, rd_en}, 32'd0);

        // two frames: enable dropped in line 2 of the second frame
        enable = 1'b1;
        for (int t = 0; t < 262; t++) begin
            @(negedge clk);
            if (t == 150) enable = 1'b0;
            decode(t - 1, rd_e, hs0, vs0, fs_e, x1, y1);
            decode(t - 2, en_e, hs1, vs1, fs_x, x2, y2);
            chk("run_rd_en", {31'b0, rd_en},       {31'b0, rd_e});
            chk("run_fs",    {31'b0, frame_start}, {31'b0, fs_e});
            chk("run_en",    {31'b0, en},          {31'b0, en_e});
            chk("run_hs",    {31'b0, hs},          {31'b0, ~hs1});
            chk("run_vs",    {31'b0, vs},          {31'b0, ~vs1});
            chk("run_hs_p",  {31'b0, hs_p},        {31'b0, hs1});
            chk("run_vs_p",  {31'b0, vs_p},        {31'b0, vs1});
            chk("run_busy",  {31'b0, busy},        {31'b0, (t < 240)});
            if (en_e) begin
                chk("run_pix_x", {20'b0, pix_x}, x2);
                chk("run_pix_y", {20'b0, pix_y}, y2);
            end
            if (t < 120) begin
                cnt_rd += int'(rd_en);
                cnt_en += int'(en);
                cnt_hs += int'(!hs);
                cnt_vs += int'(!vs);
                cnt_fs += int'(frame_start);
            end
        end
        chk("frame_rd_cnt", cnt_rd, 32'd32);
        chk("frame_en_cnt", cnt_en, 32'd32);
        chk("frame_hs_cnt", cnt_hs, 32'd24);
        chk("frame_vs_cnt", cnt_vs, 32'd30);
        chk("frame_fs_cnt", cnt_fs, 32'd1);

        // underrun: no set while rd_en is low
        enable = 1'b1;
        fifo_empty = 1'b1;
        @(negedge clk);
        fifo_empty = 1'b0;
        chk("ur_no_set_idle", {31'b0, underrun}, 32'd0);

        wait_rd(1'b1, "ur_wait1");
        fifo_empty = 1'b1;
        @(negedge clk);
        fifo_empty = 1'b0;
        chk("ur_set", {31'b0, underrun}, 32'd1);
        repeat (5) @(negedge clk);
        chk("ur_sticky", {31'b0, underrun}, 32'd1);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        chk("ur_clr", {31'b0, underrun}, 32'd0);

        wait_rd(1'b1, "ur_wait2");
        fifo_empty = 1'b1;
        @(negedge clk);
        fifo_empty = 1'b0;
        chk("ur_set2", {31'b0, underrun}, 32'd1);
        wait_rd(1'b1, "ur_wait3");
        fifo_empty = 1'b1;
        clr_underrun = 1'b1;
        @(negedge clk);
        fifo_empty = 1'b0;
        clr_underrun = 1'b0;
        chk("ur_set_wins", {31'b0, underrun}, 32'd1);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        chk("ur_clr2", {31'b0, underrun}, 32'd0);

        // reset mid-line: en with pix_x==3 means h_cnt is now 5
        k = 0;
        while (!(en === 1'b1 && pix_x == 12'd3) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("mid_found", {20'b0, pix_x}, 32'd3);
        reset = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        @(negedge clk);
        chk("mid_rst_hold", {31'b0, busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_t0_busy", {31'b0, busy},  32'd1);
        chk("post_t0_rd",   {31'b0, rd_en}, 32'd0);
        @(negedge clk);
        chk("post_t1_rd",   {31'b0, rd_en}, 32'd1);
        chk("post_t1_fs",   {31'b0, frame_start}, 32'd1);
        chk("post_t1_en",   {31'b0, en},    32'd0);
        @(negedge clk);
        chk("post_t2_en",   {31'b0, en},    32'd1);
        chk("post_t2_fs",   {31'b0, frame_start}, 32'd0);
        chk("post_pix_x",   {20'b0, pix_x}, 32'd0);
        chk("post_pix_y",   {20'b0, pix_y}, 32'd0);
        @(negedge clk);
        chk("post_pix_x1",  {20'b0, pix_x}, 32'd1);

        enable = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
